// File: rtl/pkt_write_pkg.sv
// Shared definitions for the sink-side packet write controller:
// state encoding and default sizing constants.
package pkt_write_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MAX_LEN = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    DONE  = ST_DONE,
    DRAIN = ST_DRAIN
  } state_t;

endpackage

// File: rtl/pkt_write_ctrl_beat_counter.sv
// Beat counter for the packet currently being written; saturates at MAX_LEN
// so the controller can detect an overlength packet on the next beat.
module pkt_beat_counter #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             snk_clock,
  input  logic             snk_reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             incr,
  output logic [LEN_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == LEN_W'(MAX_LEN));

  always_ff @(posedge snk_clock or posedge snk_reset) begin
    if (snk_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= LEN_W'(1);
    end else if (incr && !at_max) begin
      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: rtl/pkt_write_ctrl.sv
// Sink-side packet write controller: zero-latency FIFO writes, length
// measurement/limit, framing error flags and a done pulse per packet.
module pkt_write_ctrl
  import pkt_write_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic              snk_clock,
  input  logic              snk_reset,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              src_ready,
  input  logic              fifo_full,
  output logic              snk_ready,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              snk_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              err_sop,
  output logic              err_eop,
  output logic              err_len
);

  state_t           state;
  logic             acc;
  logic             ready_c;
  logic [LEN_W-1:0] beat_cnt;
  logic             at_max;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_incr;

  // DONE inserts one bubble so the done pulse never overlaps a new sop.
  always_comb begin
    ready_c = 1'b0;
    unique case (state)
      IDLE, WRITE: ready_c = src_ready && !fifo_full;
      DRAIN:       ready_c = 1'b1;
      DONE:        ready_c = 1'b0;
    endcase
  end

  assign snk_ready  = ready_c;
  assign acc        = snk_valid && ready_c;
  assign fifo_we    = acc && (((state == IDLE) && snk_sop) ||
                              ((state == WRITE) && !at_max));
  assign fifo_wdata = snk_data;

  assign cnt_clear = (state == DONE) || (state == DRAIN);
  assign cnt_load  = acc && (state == IDLE) && snk_sop;
  assign cnt_incr  = acc && (state == WRITE);

  pkt_beat_counter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_beat_counter (
    .snk_clock (snk_clock),
    .snk_reset (snk_reset),
    .clear     (cnt_clear),
    .load_one  (cnt_load),
    .incr      (cnt_incr),
    .count     (beat_cnt),
    .at_max    (at_max)
  );

  always_ff @(posedge snk_clock or posedge snk_reset) begin
    if (snk_reset) begin
      state    <= IDLE;
      snk_done <= 1'b0;
      pkt_len  <= '0;
      pkt_cnt  <= '0;
      err_sop  <= 1'b0;
      err_eop  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      snk_done <= 1'b0;
      err_sop  <= 1'b0;
      err_eop  <= 1'b0;
      err_len  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            if (snk_sop && snk_eop) begin
              snk_done <= 1'b1;
              pkt_len  <= LEN_W'(1);
              pkt_cnt  <= pkt_cnt + CNT_W'(1);
              state    <= DONE;
            end else if (snk_sop) begin
              state <= WRITE;
            end else if (snk_eop) begin
              err_eop <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (acc) begin
            if (snk_sop) begin
              err_sop <= 1'b1;
            end
            // A beat arriving with MAX_LEN already written is never stored.
            if (at_max) begin
              err_len <= 1'b1;
              state   <= snk_eop ? IDLE : DRAIN;
            end else if (snk_eop) begin
              snk_done <= 1'b1;
              pkt_len  <= beat_cnt + LEN_W'(1);
              pkt_cnt  <= pkt_cnt + CNT_W'(1);
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (acc && snk_eop) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_write_ctrl.sv
// Directed bench for pkt_write_ctrl with scoreboard queues for FIFO data
// and done/length/count results.
module tb_pkt_write_ctrl;

  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              snk_clock = 1'b0;
  logic              snk_reset;
  logic              snk_valid;
  logic              snk_sop;
  logic              snk_eop;
  logic [DATA_W-1:0] snk_data;
  logic              src_ready;
  logic              fifo_full;
  logic              snk_ready;
  logic              fifo_we;
  logic [DATA_W-1:0] fifo_wdata;
  logic              snk_done;
  logic [LEN_W-1:0]  pkt_len;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              err_sop;
  logic              err_eop;
  logic              err_len;

  int checks = 0;
  int errors = 0;
  int exp_data_q[$];
  int exp_len_q[$];
  int exp_cnt_q[$];
  int exp_pkt_cnt = 0;
  int n_err_sop = 0;
  int n_err_eop = 0;
  int n_err_len = 0;

  pkt_write_ctrl #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .snk_clock  (snk_clock),
    .snk_reset  (snk_reset),
    .snk_valid  (snk_valid),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .snk_data   (snk_data),
    .src_ready  (src_ready),
    .fifo_full  (fifo_full),
    .snk_ready  (snk_ready),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .snk_done   (snk_done),
    .pkt_len    (pkt_len),
    .pkt_cnt    (pkt_cnt),
    .err_sop    (err_sop),
    .err_eop    (err_eop),
    .err_len    (err_len)
  );

  always #5 snk_clock = ~snk_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every FIFO write and every done pulse must match the
  // oldest outstanding expectation.
  always @(negedge snk_clock) begin
    if (!snk_reset) begin
      if (fifo_we) begin
        if (exp_data_q.size() == 0) chk("unexpected_we", {31'd0, fifo_we}, 32'd0);
        else chk("fifo_wdata", {16'd0, fifo_wdata}, exp_data_q.pop_front());
      end
      if (snk_done) begin
        if (exp_len_q.size() == 0) chk("unexpected_done", {31'd0, snk_done}, 32'd0);
        else begin
          chk("sb_pkt_len", {28'd0, pkt_len}, exp_len_q.pop_front());
          chk("sb_pkt_cnt", {30'd0, pkt_cnt}, exp_cnt_q.pop_front());
        end
      end
      if (err_sop) n_err_sop++;
      if (err_eop) n_err_eop++;
      if (err_len) n_err_len++;
    end
  end

  // One beat: optional expected write, optional expected completion (len>0).
  task automatic beat(input logic sop, input logic eop, input logic [DATA_W-1:0] d,
                      input bit wr, input int len);
    int waited;
    snk_valid = 1'b1;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_data  = d;
    if (wr) exp_data_q.push_back(int'(d));
    if (len > 0) begin
      exp_pkt_cnt = (exp_pkt_cnt + 1) % (1 << CNT_W);
      exp_len_q.push_back(len);
      exp_cnt_q.push_back(exp_pkt_cnt);
    end
    waited = 0;
    @(negedge snk_clock);
    while (!snk_ready && waited < 50) begin
      @(negedge snk_clock);
      waited++;
    end
    if (!snk_ready) chk("ready_timeout", {31'd0, snk_ready}, 32'd1);
    @(posedge snk_clock);
    #1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic packet(input int n, input int base);
    for (int i = 0; i < n; i++)
      beat(i == 0, i == n - 1, DATA_W'(base + i), 1'b1, (i == n - 1) ? n : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    snk_reset = 1'b1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_data  = '0;
    src_ready = 1'b1;
    fifo_full = 1'b0;
    repeat (2) @(posedge snk_clock);
    @(negedge snk_clock);
    chk("rst_done",    {31'd0, snk_done}, 32'd0);
    chk("rst_pkt_len", {28'd0, pkt_len},  32'd0);
    chk("rst_pkt_cnt", {30'd0, pkt_cnt},  32'd0);
    chk("rst_err_sop", {31'd0, err_sop},  32'd0);
    chk("rst_err_eop", {31'd0, err_eop},  32'd0);
    chk("rst_err_len", {31'd0, err_len},  32'd0);
    chk("rst_we",      {31'd0, fifo_we},  32'd0);
    @(posedge snk_clock);
    #1;
    snk_reset = 1'b0;
    repeat (2) @(posedge snk_clock);
    #1;

    // 4-beat packet: done and bubble in the cycle after eop
    packet(4, 16'h100);
    @(negedge snk_clock);
    chk("p4_done",    {31'd0, snk_done},  32'd1);
    chk("p4_ready",   {31'd0, snk_ready}, 32'd0);
    chk("p4_pkt_len", {28'd0, pkt_len},   32'd4);
    chk("p4_pkt_cnt", {30'd0, pkt_cnt},   32'd1);
    @(posedge snk_clock);
    #1;
    @(negedge snk_clock);
    chk("p4_done_once", {31'd0, snk_done}, 32'd0);
    @(posedge snk_clock);
    #1;

    // single-beat packet
    beat(1'b1, 1'b1, 16'h200, 1'b1, 1);
    @(negedge snk_clock);
    chk("p1_done",    {31'd0, snk_done}, 32'd1);
    chk("p1_pkt_len", {28'd0, pkt_len},  32'd1);
    @(posedge snk_clock);
    #1;

    // overlength: 10 beats, only MAX_LEN written, then drain
    for (int i = 0; i < 8; i++) beat(i == 0, 1'b0, DATA_W'(16'h300 + i), 1'b1, 0);
    beat(1'b0, 1'b0, 16'h308, 1'b0, 0);
    @(negedge snk_clock);
    chk("ovl_err_len", {31'd0, err_len},   32'd1);
    chk("ovl_ready",   {31'd0, snk_ready}, 32'd1);
    @(posedge snk_clock);
    #1;
    beat(1'b0, 1'b1, 16'h309, 1'b0, 0);
    @(negedge snk_clock);
    chk("ovl_no_done", {31'd0, snk_done}, 32'd0);
    chk("ovl_pkt_cnt", {30'd0, pkt_cnt},  32'(exp_pkt_cnt));
    @(posedge snk_clock);
    #1;
    packet(3, 16'h400);
    @(posedge snk_clock);
    #1;
    packet(MAX_LEN, 16'h480);
    @(negedge snk_clock);
    chk("max_pkt_len", {28'd0, pkt_len}, 32'(MAX_LEN));
    @(posedge snk_clock);
    #1;

    // fifo_full stall of 3 cycles before beat 2 of a 5-beat packet
    beat(1'b1, 1'b0, 16'h500, 1'b1, 0);
    beat(1'b0, 1'b0, 16'h501, 1'b1, 0);
    fifo_full = 1'b1;
    snk_valid = 1'b1;
    snk_data  = 16'h502;
    for (int i = 0; i < 3; i++) begin
      @(negedge snk_clock);
      chk("stall_ready", {31'd0, snk_ready}, 32'd0);
      chk("stall_we",    {31'd0, fifo_we},   32'd0);
      @(posedge snk_clock);
      #1;
    end
    fifo_full = 1'b0;
    beat(1'b0, 1'b0, 16'h502, 1'b1, 0);
    beat(1'b0, 1'b0, 16'h503, 1'b1, 0);
    beat(1'b0, 1'b1, 16'h504, 1'b1, 5);
    @(negedge snk_clock);
    chk("stall_pkt_len", {28'd0, pkt_len}, 32'd5);
    @(posedge snk_clock);
    #1;

    // framing errors
    beat(1'b0, 1'b1, 16'h600, 1'b0, 0);
    @(negedge snk_clock);
    chk("err_eop_pulse", {31'd0, err_eop}, 32'd1);
    @(posedge snk_clock);
    #1;
    beat(1'b1, 1'b0, 16'h700, 1'b1, 0);
    beat(1'b0, 1'b0, 16'h701, 1'b1, 0);
    beat(1'b1, 1'b0, 16'h702, 1'b1, 0);
    @(negedge snk_clock);
    chk("err_sop_pulse", {31'd0, err_sop}, 32'd1);
    @(posedge snk_clock);
    #1;
    beat(1'b0, 1'b0, 16'h703, 1'b1, 0);
    beat(1'b0, 1'b1, 16'h704, 1'b1, 5);
    @(negedge snk_clock);
    chk("sop_pkt_len", {28'd0, pkt_len}, 32'd5);
    @(posedge snk_clock);
    #1;

    // reset mid-packet
    beat(1'b1, 1'b0, 16'h800, 1'b1, 0);
    beat(1'b0, 1'b0, 16'h801, 1'b1, 0);
    snk_reset = 1'b1;
    @(negedge snk_clock);
    chk("mid_rst_done",    {31'd0, snk_done}, 32'd0);
    chk("mid_rst_pkt_len", {28'd0, pkt_len},  32'd0);
    chk("mid_rst_pkt_cnt", {30'd0, pkt_cnt},  32'd0);
    chk("mid_rst_errs",    {29'd0, err_sop, err_eop, err_len}, 32'd0);
    @(posedge snk_clock);
    #1;
    snk_reset   = 1'b0;
    exp_pkt_cnt = 0;
    @(posedge snk_clock);
    #1;
    packet(3, 16'h900);
    @(negedge snk_clock);
    chk("post_rst_len", {28'd0, pkt_len}, 32'd3);
    chk("post_rst_cnt", {30'd0, pkt_cnt}, 32'd1);
    @(posedge snk_clock);
    #1;
    for (int p = 0; p < 4; p++) begin
      packet(2, 16'hA00 + 16 * p);
      @(posedge snk_clock);
      #1;
    end
    @(negedge snk_clock);
    chk("wrap_pkt_cnt", {30'd0, pkt_cnt}, 32'd1);
    repeat (3) @(posedge snk_clock);
    @(negedge snk_clock);

    chk("n_err_sop", 32'(n_err_sop), 32'd1);
    chk("n_err_eop", 32'(n_err_eop), 32'd1);
    chk("n_err_len", 32'(n_err_len), 32'd1);
    chk("data_q_left", 32'(exp_data_q.size()), 32'd0);
    chk("done_q_left", 32'(exp_len_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_write_ctrl.md
Name: pkt_write_ctrl

Overview:
Parametrised sink-side packet write controller. It accepts Avalon-ST style packets (sop/eop/valid/ready) and writes each accepted beat into the downstream packet FIFO with zero latency. It measures packet length, enforces a maximum length and flags framing errors. On completion it issues a done pulse with the packet length to the sort engine.

Parameters:
DATA_W, 16, data beat width
MAX_LEN, 256, max beats per packet (>=1)
LEN_W, $clog2(MAX_LEN+1), width of length counter/output
CNT_W, 16, width of completed-packet counter (wraps)

Ports:
snk_clock  in  1  clock
snk_reset  in  1  asynchronous reset, active-high
snk_valid  in  1  sink beat valid
snk_sop  in  1  start of packet, qualified by snk_valid
snk_eop  in  1  end of packet, qualified by snk_valid
snk_data  in  DATA_W  sink beat data
src_ready  in  1  downstream ready (1 = ready, 0 = busy)
fifo_full  in  1  packet FIFO full
snk_ready  out  1  sink backpressure
fifo_we  out  1  FIFO write enable
fifo_wdata  out  DATA_W  FIFO write data (= snk_data)
snk_done  out  1  one-cycle pulse: packet complete
pkt_len  out  LEN_W  beats in last completed packet, held until next done
pkt_cnt  out  CNT_W  completed packets since reset, wraps
err_sop  out  1  pulse: sop seen inside a packet
err_eop  out  1  pulse: eop seen outside a packet
err_len  out  1  pulse: packet exceeded MAX_LEN

Behaviour:
- Reset: snk_clock domain; snk_reset asynchronous, active-high. State=IDLE; beat counter, pkt_len, pkt_cnt = 0; all pulse outputs 0. Reset mid-packet abandons the packet; no done or error pulse is generated for it.
- Beat accepted (acc) = snk_valid && snk_ready.
- snk_ready: in IDLE/WRITE = src_ready && !fifo_full; in DRAIN = 1; in DONE = 0 (one bubble cycle per packet).
- fifo_we is combinational: acc && (state==IDLE && snk_sop || state==WRITE) && not overlength. fifo_wdata = snk_data. Zero latency.
- snk_done, pkt_len, pkt_cnt and err_* are registered. Each asserts one cycle after the causing beat.
- FSM (2-bit):
  - IDLE: on acc&&sop&&!eop, write the beat, cnt=1, go WRITE. On acc&&sop&&eop, write the beat, len=1, go DONE. On acc&&eop&&!sop, drop the beat and pulse err_eop. Other accepted beats are dropped silently.
  - WRITE: on each acc, cnt+1.
    - acc&&sop: pulse err_sop; the beat is written as data, with no restart.
    - acc&&eop with cnt+1<=MAX_LEN: write the beat, go DONE.
    - acc when cnt==MAX_LEN and !eop: beat not written, pulse err_len, go DRAIN.
    - If cnt==MAX_LEN and the beat has eop: not written, err_len, go IDLE with no done.
  - DRAIN: consume and discard beats until acc&&eop, then go IDLE. No done; pkt_cnt unchanged.
  - DONE: snk_done=1 for exactly one cycle; pkt_len=final count; pkt_cnt+1 (wraps 2^CNT_W-1 -> 0); go IDLE.
- Length is the number of beats written, sop through eop inclusive. MAX_LEN beats is legal.
- Beats with snk_valid=0 never advance the FSM or counters.
- fifo_full or src_ready deassertion mid-packet only stalls via snk_ready; the FSM holds state.
- Overlength packets leave a partial packet in the FIFO. The downstream stage uses err_len to discard it.

Decomposition:
- Shared package pkt_write_pkg: state encoding localparams (IDLE=0, WRITE=1, DONE=2, DRAIN=3) and the default MAX_LEN/DATA_W constants.
- One natural sub-module, pkt_beat_counter: a LEN_W counter with clear/load-1/increment and an at_max flag. The FSM, handshake logic and pkt_cnt stay in the top level.

Test Plan:
- 4-beat packet (sop on beat 0, eop on beat 3), src_ready=1, fifo_full=0 -> 4 fifo_we, data in order; snk_done one cycle after eop beat; pkt_len=4; pkt_cnt=1; snk_ready=0 in that cycle.
- Single beat with sop&&eop -> one fifo_we; snk_done; pkt_len=1.
- MAX_LEN=8, 10-beat packet -> 8 writes; err_len after beat 9; beats 9-10 dropped (snk_ready=1); no snk_done; pkt_cnt unchanged; next good packet completes with pkt_len correct.
- fifo_full asserted for 3 cycles mid-packet -> snk_ready=0, no fifo_we during stall; pkt_len still equals beats sent.
- Framing errors: eop-only beat in IDLE -> err_eop, no write; sop on beat 2 of a 5-beat packet -> err_sop, 5 writes, pkt_len=5.
- snk_reset pulsed after beat 2 of a packet -> all outputs 0; following 3-beat packet gives pkt_len=3, pkt_cnt=1. With CNT_W=2, 5 packets -> pkt_cnt wraps to 1.
